// File: rtl/lut_cfg_loader.sv
// Streams configuration words into per-LUT truth-table masks and evaluates the LUTs once loading completes.
// Optional trailing checksum word enabled by defining LUT_CFG_CHECKSUM_EN.
//
// state | meaning
// IDLE  | no load in progress, LUTs inactive
// LOAD  | accepting data words into the mask registers
// CHECK | expecting the XOR checksum word (LUT_CFG_CHECKSUM_EN only)
// DONE  | all masks loaded, LUT outputs active
// ERROR | checksum mismatch, LUT outputs held at 0
module lut_cfg_loader #(
    parameter int K        = 6,
    parameter int NUM_LUTS = 8,
    parameter int WORD_W   = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         cfg_start,
    input  logic [WORD_W-1:0]            cfg_data,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    output logic                         cfg_done,
    output logic                         cfg_error,
    input  logic [NUM_LUTS*K-1:0]        lut_in,
    output logic [NUM_LUTS-1:0]          lut_out,
    output logic [NUM_LUTS*(2**K)-1:0]   lut_masks
);

    localparam int M     = 2 ** K;
    localparam int WPL   = (M + WORD_W - 1) / WORD_W;
    localparam int TOTAL = NUM_LUTS * WPL;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

`ifdef LUT_CFG_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, DONE, ERROR} state_t;
`endif

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_LUTS*M-1:0]       masks_q, masks_d;
    logic                        xfer;
`ifdef LUT_CFG_CHECKSUM_EN
    logic [WORD_W-1:0]           xor_q, xor_d;
`endif

    assign xfer = cfg_valid && cfg_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        masks_d = masks_q;
`ifdef LUT_CFG_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        if (cfg_start) begin
            // restart wins over a same-cycle transfer, which is dropped
            state_d = LOAD;
            cnt_d   = '0;
            masks_d = '0;
`ifdef LUT_CFG_CHECKSUM_EN
            xor_d   = '0;
`endif
        end else if (xfer) begin
            case (state_q)
                LOAD: begin
                    for (int i = 0; i < NUM_LUTS; i++) begin
                        for (int s = 0; s < WPL; s++) begin
                            if (cnt_q == CNT_W'(i * WPL + s)) begin
                                for (int b = 0; b < WORD_W; b++) begin
                                    // tail bits of the last slot past M are dropped
                                    if (s * WORD_W + b < M)
                                        masks_d[i*M + s*WORD_W + b] = cfg_data[b];
                                end
                            end
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef LUT_CFG_CHECKSUM_EN
                    xor_d = xor_q ^ cfg_data;
                    if (cnt_q == CNT_W'(TOTAL - 1)) state_d = CHECK;
`else
                    if (cnt_q == CNT_W'(TOTAL - 1)) state_d = DONE;
`endif
                end
`ifdef LUT_CFG_CHECKSUM_EN
                CHECK: state_d = (cfg_data == xor_q) ? DONE : ERROR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            masks_q <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            masks_q <= masks_d;
`ifdef LUT_CFG_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

`ifdef LUT_CFG_CHECKSUM_EN
    assign cfg_ready = (state_q == LOAD) || (state_q == CHECK);
    assign cfg_error = (state_q == ERROR);
`else
    assign cfg_ready = (state_q == LOAD);
    assign cfg_error = 1'b0;
`endif
    assign cfg_done  = (state_q == DONE);
    assign lut_masks = masks_q;

    always_comb begin
        lut_out = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (cfg_done)
                lut_out[i] = masks_q[i*M + int'(lut_in[i*K +: K])];
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: behavioural mask/handshake model checked every cycle plus literal pins.
// Covers the LUT_CFG_CHECKSUM_EN build when that macro is defined for both files.
module tb_lut_cfg_loader;

    localparam int K = 4, NL = 2, WW = 8, M = 16, WPL = 2, TOTAL = 4;

    logic                 clock = 1'b0;
    logic                 reset_n, cfg_start, cfg_valid;
    logic [WW-1:0]        cfg_data;
    logic                 cfg_ready, cfg_done, cfg_error;
    logic [NL*K-1:0]      lut_in;
    logic [NL-1:0]        lut_out;
    logic [NL*M-1:0]      lut_masks;

    always #5 clock = ~clock;

    lut_cfg_loader #(.K(K), .NUM_LUTS(NL), .WORD_W(WW)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_start(cfg_start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_done(cfg_done), .cfg_error(cfg_error), .lut_in(lut_in),
        .lut_out(lut_out), .lut_masks(lut_masks)
    );

    int n_pass = 0;
    int n_tot  = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: word n lands in LUT n/WPL, byte n%WPL
    logic [M-1:0]  m_mask [NL];
    int            m_n;
    logic          m_ready, m_done, m_err;
    logic [WW-1:0] m_xor;

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NL; i++) m_mask[i] <= '0;
            m_n <= 0; m_ready <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_xor <= '0;
        end else if (cfg_start) begin
            for (int i = 0; i < NL; i++) m_mask[i] <= '0;
            m_n <= 0; m_ready <= 1'b1; m_done <= 1'b0; m_err <= 1'b0; m_xor <= '0;
        end else if (cfg_valid && m_ready) begin
            if (m_n < TOTAL) begin
                m_mask[m_n / WPL][(m_n % WPL) * WW +: WW] <= cfg_data;
                m_xor <= m_xor ^ cfg_data;
                m_n   <= m_n + 1;
`ifndef LUT_CFG_CHECKSUM_EN
                if (m_n == TOTAL - 1) begin
                    m_ready <= 1'b0;
                    m_done  <= 1'b1;
                end
`endif
            end else begin
                m_ready <= 1'b0;
                if (cfg_data == m_xor) m_done <= 1'b1;
                else m_err <= 1'b1;
            end
        end
    end

    function automatic logic [NL-1:0] model_out();
        logic [NL-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++)
            if (m_done) r[i] = m_mask[i][lut_in[i*K +: K]];
        return r;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_ready", cfg_ready, m_ready);
            chk("model_done", cfg_done, m_done);
            chk("model_error", cfg_error, m_err);
            chk("model_masks", lut_masks, {m_mask[1], m_mask[0]});
            chk("model_lut_out", lut_out, model_out());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("ready_after_start", cfg_ready, 1'b1);
    endtask

    // back-to-back words; cs is the trailing checksum in the macro build
    task automatic load_seq(input logic [7:0] a, b, c, d, input logic [7:0] cs);
        logic [7:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        cfg_valid = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            cfg_data = w[i];
            tick();
        end
`ifdef LUT_CFG_CHECKSUM_EN
        chk("done_before_cksum", cfg_done, 1'b0);
        cfg_data = cs;
        tick();
`endif
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] w [4];
        int acc, cyc, need;
        w[0] = 8'h96; w[1] = 8'h69; w[2] = 8'h00; w[3] = 8'h80;
        reset_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; lut_in = '0;
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_masks", lut_masks, 32'h0);
        chk("reset_ready", cfg_ready, 1'b0);
        chk("reset_done", cfg_done, 1'b0);
        reset_n = 1'b1;
        tick();

        // back-to-back load
        start_pulse();
        load_seq(8'h96, 8'h69, 8'h00, 8'h80, 8'h7F);
        chk("b2b_masks", lut_masks, 32'h8000_6996);
        chk("b2b_done", cfg_done, 1'b1);
        chk("b2b_error", cfg_error, 1'b0);
        chk("b2b_ready_low", cfg_ready, 1'b0);
        lut_in = 8'hF5; #1;
        chk("lut_F5", lut_out, 2'b10);
        lut_in = 8'hF1; #1;
        chk("lut_F1", lut_out, 2'b11);
        cfg_valid = 1'b1; cfg_data = 8'h12;
        tick();
        cfg_valid = 1'b0;
        chk("done_ignores_word", lut_masks, 32'h8000_6996);

        // valid toggling every other cycle
`ifdef LUT_CFG_CHECKSUM_EN
        need = TOTAL + 1;
`else
        need = TOTAL;
`endif
        start_pulse();
        acc = 0; cyc = 0;
        while (acc < need && cyc < 20) begin
            cfg_valid = (cyc % 2 == 0);
            cfg_data  = (acc < TOTAL) ? w[acc] : 8'h7F;
            if (cfg_valid && acc == need - 1) chk("toggle_done_early", cfg_done, 1'b0);
            tick();
            if (cfg_valid) acc++;
            cyc++;
        end
        cfg_valid = 1'b0;
        chk("toggle_accepts", acc, need);
        chk("toggle_masks", lut_masks, 32'h8000_6996);
        chk("toggle_done", cfg_done, 1'b1);

        // restart mid-load, simultaneous word dropped
        start_pulse();
        cfg_valid = 1'b1;
        cfg_data = 8'h96; tick();
        cfg_data = 8'h69; tick();
        cfg_start = 1'b1; cfg_data = 8'h55;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        chk("restart_clears", lut_masks, 32'h0);
        chk("restart_ready", cfg_ready, 1'b1);
        load_seq(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        chk("restart_masks", lut_masks, 32'hFFFF_FFFF);
        chk("restart_done", cfg_done, 1'b1);

`ifdef LUT_CFG_CHECKSUM_EN
        start_pulse();
        load_seq(8'h96, 8'h69, 8'h00, 8'h80, 8'h7E);
        chk("bad_cksum_error", cfg_error, 1'b1);
        chk("bad_cksum_done", cfg_done, 1'b0);
        for (int v = 0; v < 256; v += 17) begin
            lut_in = 8'(v); #1;
            chk("bad_cksum_lut_out", lut_out, 2'b00);
        end
`endif

        // reset mid-load, then valid ignored
        start_pulse();
        cfg_valid = 1'b1;
        cfg_data = 8'h96; tick();
        cfg_data = 8'h69; tick();
        cfg_valid = 1'b0;
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("rst_mid_masks", lut_masks, 32'h0);
        chk("rst_mid_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b1; cfg_data = 8'hAB;
        tick(); tick(); tick();
        cfg_valid = 1'b0;
        chk("rst_mid_ignored", lut_masks, 32'h0);

        // reset from DONE
        start_pulse();
        load_seq(8'h96, 8'h69, 8'h00, 8'h80, 8'h7F);
        chk("pre_rst_done", cfg_done, 1'b1);
        lut_in = 8'hF5;
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("rst_done_masks", lut_masks, 32'h0);
        chk("rst_done_done", cfg_done, 1'b0);
        chk("rst_done_lut_out", lut_out, 2'b00);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
